cim_bank_pingpong: RTL and testbench

Parametrised, double-buffered CIM weight store. It holds ROWS words of WORD_W bits in each of two banks, labelled active and shadow.
- The compute array reads the active bank continuously, as inverted low-half and high-half buses.
- A streaming valid/ready port fills the shadow bank at an auto-incrementing row address.
- A swap request exchanges the two banks, so the next weight set loads with no compute stall.

---
 rtl/cim_bank_pingpong.sv | 105 ++++++++++
 tb/tb_cim_bank_pingpong.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_bank_pingpong.sv
// Double-buffered CIM weight store: the compute array reads the active bank as
// inverted half-word buses while a valid/ready stream fills the shadow bank.
module cim_bank_pingpong #(
    parameter  int ROWS   = 8,
    parameter  int WORD_W = 24,
    localparam int HALF_W = WORD_W / 2,
    localparam int PTR_W  = $clog2(ROWS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     load_abort,
    input  logic                     swap_req,
    output logic                     swap_ack,
    output logic                     shadow_full,
    output logic                     rd_bank,
    output logic [PTR_W-1:0]         wr_ptr,
    output logic [ROWS*HALF_W-1:0]   nW_low,
    output logic [ROWS*HALF_W-1:0]   nW_high
);

    typedef enum logic {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_t;

    state_t             state_reg, state_next;
    logic               rd_bank_reg, rd_bank_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic               ack_reg, ack_next;
    logic               wr_en;

    logic [ROWS-1:0][WORD_W-1:0] active_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_LOAD;
            rd_bank_reg <= 1'b0;
            ptr_reg     <= '0;
            ack_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rd_bank_reg <= rd_bank_next;
            ptr_reg     <= ptr_next;
            ack_reg     <= ack_next;
        end
    end

    // Abort outranks both the write and the swap; swap only looks at the
    // registered FULL state, so a final-row write cannot swap in the same edge.
    always_comb begin
        state_next   = state_reg;
        rd_bank_next = rd_bank_reg;
        ptr_next     = ptr_reg;
        ack_next     = 1'b0;
        if (load_abort) begin
            state_next = ST_LOAD;
            ptr_next   = '0;
        end else if (wr_en) begin
            if (ptr_reg == PTR_W'(ROWS - 1)) begin
                ptr_next   = '0;
                state_next = ST_FULL;
            end else begin
                ptr_next = ptr_reg + PTR_W'(1);
            end
        end else if (state_reg == ST_FULL && swap_req) begin
            state_next   = ST_LOAD;
            rd_bank_next = ~rd_bank_reg;
            ack_next     = 1'b1;
        end
    end

    always_comb begin
        wr_ready    = (state_reg == ST_LOAD);
        shadow_full = (state_reg == ST_FULL);
        wr_en       = wr_valid && (state_reg == ST_LOAD) && !load_abort;
        swap_ack    = ack_reg;
        rd_bank     = rd_bank_reg;
        wr_ptr      = ptr_reg;
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            logic [WORD_W-1:0] word0_reg;
            logic [WORD_W-1:0] word1_reg;

            // Writes land in whichever bank is not currently being read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word0_reg <= '0;
                    word1_reg <= '0;
                end else if (wr_en && ptr_reg == PTR_W'(gi)) begin
                    if (rd_bank_reg)
                        word0_reg <= wr_data;
                    else
                        word1_reg <= wr_data;
                end
            end

            assign active_word[gi] = rd_bank_reg ? word1_reg : word0_reg;
            assign nW_low[gi*HALF_W +: HALF_W]  = ~active_word[gi][HALF_W-1:0];
            assign nW_high[gi*HALF_W +: HALF_W] = ~active_word[gi][WORD_W-1:HALF_W];
        end
    endgenerate

endmodule

// File: tb/tb_cim_bank_pingpong.sv
// Directed bench for cim_bank_pingpong: default 8x24 instance plus a 4x16 instance.
module tb_cim_bank_pingpong;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        wr_valid = 0, load_abort = 0, swap_req = 0;
    logic [23:0] wr_data = '0;
    logic        wr_ready, swap_ack, shadow_full, rd_bank;
    logic [2:0]  wr_ptr;
    logic [95:0] nw_low, nw_high;

    logic        p_wr_valid = 0, p_load_abort = 0, p_swap_req = 0;
    logic [15:0] p_wr_data = '0;
    logic        p_wr_ready, p_swap_ack, p_shadow_full, p_rd_bank;
    logic [1:0]  p_wr_ptr;
    logic [31:0] p_nw_low, p_nw_high;

    cim_bank_pingpong dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .load_abort(load_abort), .swap_req(swap_req),
        .swap_ack(swap_ack), .shadow_full(shadow_full), .rd_bank(rd_bank),
        .wr_ptr(wr_ptr), .nW_low(nw_low), .nW_high(nw_high)
    );

    cim_bank_pingpong #(.ROWS(4), .WORD_W(16)) dut_p (
        .clk(clk), .rst_n(rst_n), .wr_valid(p_wr_valid), .wr_ready(p_wr_ready),
        .wr_data(p_wr_data), .load_abort(p_load_abort), .swap_req(p_swap_req),
        .swap_ack(p_swap_ack), .shadow_full(p_shadow_full), .rd_bank(p_rd_bank),
        .wr_ptr(p_wr_ptr), .nW_low(p_nw_low), .nW_high(p_nw_high)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [23:0] base, input int first, input int n);
        for (int r = first; r < first + n; r++) begin
            wr_valid = 1'b1;
            wr_data  = base + 24'(r);
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (nw_low !== {96{1'b1}} || nw_high !== {96{1'b1}}) begin
            errors++;
            $display("FAIL reset_nw: low=%h high=%h expected all ones", nw_low, nw_high);
        end
        checks++;
        if ({rd_bank, wr_ptr, wr_ready, shadow_full, swap_ack} !== 7'b0_000_1_0_0) begin
            errors++;
            $display("FAIL reset_ctrl: rd_bank=%b wr_ptr=%0d wr_ready=%b full=%b ack=%b expected 0 0 1 0 0",
                     rd_bank, wr_ptr, wr_ready, shadow_full, swap_ack);
        end
        checks++;
        if (p_nw_low !== 32'hFFFF_FFFF || p_rd_bank !== 1'b0 || p_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_p: nw_low=%h rd_bank=%b wr_ready=%b expected ffffffff 0 1",
                     p_nw_low, p_rd_bank, p_wr_ready);
        end
        #2 rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_full_load_swap();
        load_words(24'hABC123, 0, 8);
        checks++;
        if (shadow_full !== 1'b1 || wr_ready !== 1'b0 || wr_ptr !== 3'd0) begin
            errors++;
            $display("FAIL load_full: full=%b wr_ready=%b wr_ptr=%0d expected 1 0 0",
                     shadow_full, wr_ready, wr_ptr);
        end
        checks++;
        if (nw_low !== {96{1'b1}}) begin
            errors++;
            $display("FAIL active_untouched: nw_low=%h expected all ones", nw_low);
        end
        do_swap();
        checks++;
        if (swap_ack !== 1'b1 || rd_bank !== 1'b1 || shadow_full !== 1'b0) begin
            errors++;
            $display("FAIL swap: ack=%b rd_bank=%b full=%b expected 1 1 0", swap_ack, rd_bank, shadow_full);
        end
        checks++;
        if (nw_low[11:0] !== 12'hEDC || nw_high[11:0] !== 12'h543) begin
            errors++;
            $display("FAIL swap_row0: low=%h high=%h expected edc 543", nw_low[11:0], nw_high[11:0]);
        end
        checks++;
        if (nw_low[84 +: 12] !== 12'hED5 || nw_high[84 +: 12] !== 12'h543) begin
            errors++;
            $display("FAIL swap_row7: low=%h high=%h expected ed5 543", nw_low[84 +: 12], nw_high[84 +: 12]);
        end
        step();
        checks++;
        if (swap_ack !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ack_pulse: ack=%b wr_ready=%b expected 0 1", swap_ack, wr_ready);
        end
        $display("test_full_load_swap done");
    endtask

    task automatic test_backpressure();
        load_words(24'h5A5300, 0, 3);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        checks++;
        if (swap_ack !== 1'b0 || rd_bank !== 1'b1 || wr_ptr !== 3'd3) begin
            errors++;
            $display("FAIL early_swap: ack=%b rd_bank=%b wr_ptr=%0d expected 0 1 3", swap_ack, rd_bank, wr_ptr);
        end
        load_words(24'h5A5300, 3, 5);
        wr_valid = 1'b1;
        wr_data  = 24'hFFFFFF;
        step();
        step();
        checks++;
        if (wr_ready !== 1'b0 || wr_ptr !== 3'd0 || shadow_full !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: wr_ready=%b wr_ptr=%0d full=%b expected 0 0 1", wr_ready, wr_ptr, shadow_full);
        end
        wr_valid = 1'b0;
        do_swap();
        checks++;
        if (swap_ack !== 1'b1 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL bp_swap: ack=%b rd_bank=%b expected 1 0", swap_ack, rd_bank);
        end
        checks++;
        if (nw_low[11:0] !== 12'hCFF || nw_high[11:0] !== 12'hA5A || nw_low[84 +: 12] !== 12'hCF8) begin
            errors++;
            $display("FAIL bp_rows: row0 low=%h high=%h row7 low=%h expected cff a5a cf8",
                     nw_low[11:0], nw_high[11:0], nw_low[84 +: 12]);
        end
        step();
        $display("test_backpressure done");
    endtask

    task automatic test_abort();
        load_words(24'h777700, 0, 5);
        checks++;
        if (wr_ptr !== 3'd5) begin
            errors++;
            $display("FAIL abort_pre: wr_ptr=%0d expected 5", wr_ptr);
        end
        load_abort = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 24'hFFFFFF;
        swap_req   = 1'b1;
        step();
        load_abort = 1'b0;
        wr_valid   = 1'b0;
        swap_req   = 1'b0;
        checks++;
        if (wr_ptr !== 3'd0 || shadow_full !== 1'b0 || swap_ack !== 1'b0 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL abort: wr_ptr=%0d full=%b ack=%b rd_bank=%b expected 0 0 0 0",
                     wr_ptr, shadow_full, swap_ack, rd_bank);
        end
        load_words(24'h246800, 0, 8);
        do_swap();
        checks++;
        if (rd_bank !== 1'b1 || nw_low[11:0] !== 12'h7FF || nw_high[11:0] !== 12'hDB9
            || nw_low[48 +: 12] !== 12'h7FB) begin
            errors++;
            $display("FAIL abort_reload: rd_bank=%b row0 low=%h high=%h row4 low=%h expected 1 7ff db9 7fb",
                     rd_bank, nw_low[11:0], nw_high[11:0], nw_low[48 +: 12]);
        end
        step();
        $display("test_abort done");
    endtask

    task automatic test_collision();
        load_words(24'h135700, 0, 7);
        wr_valid = 1'b1;
        wr_data  = 24'h135707;
        swap_req = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++;
        if (shadow_full !== 1'b1 || swap_ack !== 1'b0 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL collide: full=%b ack=%b rd_bank=%b expected 1 0 1", shadow_full, swap_ack, rd_bank);
        end
        step();
        checks++;
        if (swap_ack !== 1'b1 || rd_bank !== 1'b0 || nw_low[84 +: 12] !== 12'h8F8 || nw_high[84 +: 12] !== 12'hECA) begin
            errors++;
            $display("FAIL collide_swap: ack=%b rd_bank=%b row7 low=%h high=%h expected 1 0 8f8 eca",
                     swap_ack, rd_bank, nw_low[84 +: 12], nw_high[84 +: 12]);
        end
        step();
        swap_req = 1'b0;
        checks++;
        if (swap_ack !== 1'b0 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL held_swap: ack=%b rd_bank=%b expected 0 0", swap_ack, rd_bank);
        end
        $display("test_collision done");
    endtask

    task automatic test_midrun_reset();
        load_words(24'h0F0F00, 0, 8);
        do_swap();
        load_words(24'h0F0F00, 0, 2);
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (nw_low !== {96{1'b1}} || nw_high !== {96{1'b1}} || rd_bank !== 1'b0 || wr_ptr !== 3'd0
            || wr_ready !== 1'b1 || shadow_full !== 1'b0 || swap_ack !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: rd_bank=%b wr_ptr=%0d ready=%b full=%b ack=%b low=%h",
                     rd_bank, wr_ptr, wr_ready, shadow_full, swap_ack, nw_low);
        end
        #2 rst_n = 1'b1;
        step();
        $display("test_midrun_reset done");
    endtask

    task automatic test_param_sweep();
        for (int r = 0; r < 4; r++) begin
            p_wr_valid = 1'b1;
            p_wr_data  = 16'hC300 + 16'(r);
            step();
        end
        p_wr_valid = 1'b0;
        checks++;
        if (p_shadow_full !== 1'b1 || p_wr_ptr !== 2'd0 || p_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL p_full: full=%b wr_ptr=%0d ready=%b expected 1 0 0", p_shadow_full, p_wr_ptr, p_wr_ready);
        end
        p_swap_req = 1'b1;
        step();
        p_swap_req = 1'b0;
        checks++;
        if (p_swap_ack !== 1'b1 || p_rd_bank !== 1'b1 || p_nw_low !== 32'hFCFDFEFF || p_nw_high !== 32'h3C3C3C3C) begin
            errors++;
            $display("FAIL p_set_a: ack=%b rd_bank=%b low=%h high=%h expected 1 1 fcfdfeff 3c3c3c3c",
                     p_swap_ack, p_rd_bank, p_nw_low, p_nw_high);
        end
        for (int r = 0; r < 4; r++) begin
            p_wr_valid = 1'b1;
            p_wr_data  = 16'h5A10 + 16'(r);
            step();
        end
        p_wr_valid = 1'b0;
        p_swap_req = 1'b1;
        step();
        p_swap_req = 1'b0;
        checks++;
        if (p_swap_ack !== 1'b1 || p_rd_bank !== 1'b0 || p_nw_low !== 32'hECEDEEEF || p_nw_high !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL p_set_b: ack=%b rd_bank=%b low=%h high=%h expected 1 0 ecedeeef a5a5a5a5",
                     p_swap_ack, p_rd_bank, p_nw_low, p_nw_high);
        end
        step();
        $display("test_param_sweep done");
    endtask

    initial begin
        test_reset();
        test_full_load_swap();
        test_backpressure();
        test_abort();
        test_collision();
        test_midrun_reset();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
